// File: rtl/line_pkg.sv
// Shared definitions for the half-duplex line transceiver pair.
// Receive FSM states and the line levels of a UART-style frame.
package line_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/line_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs.
// The reset value is a parameter so idle-high and idle-low pads can share it.
module line_sync2
    import line_pkg::*;
#(
    parameter logic RESET_VAL = LINE_IDLE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/half_duplex_line_rx.sv
// Receiver for the shared half-duplex line: recovers start/data/stop frames
// while the local driver is off and offers each word on a valid/ready port.
module half_duplex_line_rx
    import line_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_in,
    input  logic              rx_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] DONE_IDX  = IDX_W'(DATA_W);

    logic              w_line_s;

    rx_state_t         r_state;
    rx_state_t         w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic              w_load;
    logic              w_stop_bad;

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_ferr;
    logic              r_ovr;

    line_sync2 #(
        .RESET_VAL (LINE_IDLE)
    ) u_line_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (line_in),
        .o_sync  (w_line_s)
    );

    // Dropping rx_en means the local driver owns the line, so any partial frame is abandoned.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_load       = 1'b0;
        w_stop_bad   = 1'b0;

        if (r_state != IDLE && !rx_en) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_idx_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_en && w_line_s == START_BIT) begin
                        w_state_next = START;
                        w_cnt_next   = '0;
                        w_idx_next   = '0;
                    end
                end

                START: begin
                    if (r_cnt == HALF_TERM) begin
                        w_cnt_next   = '0;
                        w_state_next = (w_line_s == START_BIT) ? DATA : IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_cnt == FULL_TERM) begin
                        w_cnt_next   = '0;
                        w_shift_next = {w_line_s, r_shift[DATA_W-1:1]};
                        if (r_idx == LAST_IDX) begin
                            w_state_next = STOP;
                            w_idx_next   = DONE_IDX;
                        end else begin
                            w_idx_next = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (r_cnt == FULL_TERM) begin
                        w_cnt_next   = '0;
                        w_state_next = IDLE;
                        if (w_line_s == STOP_BIT) begin
                            w_load = 1'b1;
                        end else begin
                            w_stop_bad = 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
        end
    end

    // Single-entry holding register: a fresh word always replaces an unread one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_stop_bad;
            r_ovr  <= 1'b0;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_ovr   <= r_valid && !data_ready;
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign busy       = (r_state != IDLE);

endmodule
